// File: rtl/tl_fifo_fixer_ordered.sv
// TileLink FIFO fixer that keeps responses in order per source group: a new request is held
// while its group still has transactions in flight to a different FIFO domain.
module tl_fifo_fixer_ordered #(
  parameter int unsigned ADDR_W      = 31,
  parameter int unsigned SRC_W       = 8,
  parameter int unsigned DATA_W      = 64,
  parameter int unsigned GROUP_SHIFT = 4,
  parameter int unsigned NUM_GROUPS  = 16,
  parameter int unsigned ID_LO       = 28,
  parameter int unsigned ID_W        = 2,
  parameter int unsigned CNT_W       = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                auto_in_a_valid,
  output logic                auto_in_a_ready,
  input  logic [2:0]          auto_in_a_bits_opcode,
  input  logic [2:0]          auto_in_a_bits_param,
  input  logic [3:0]          auto_in_a_bits_size,
  input  logic [SRC_W-1:0]    auto_in_a_bits_source,
  input  logic [ADDR_W-1:0]   auto_in_a_bits_address,
  input  logic [DATA_W/8-1:0] auto_in_a_bits_mask,
  input  logic [DATA_W-1:0]   auto_in_a_bits_data,
  input  logic                auto_in_a_bits_corrupt,
  output logic                auto_out_a_valid,
  input  logic                auto_out_a_ready,
  output logic [2:0]          auto_out_a_bits_opcode,
  output logic [2:0]          auto_out_a_bits_param,
  output logic [3:0]          auto_out_a_bits_size,
  output logic [SRC_W-1:0]    auto_out_a_bits_source,
  output logic [ADDR_W-1:0]   auto_out_a_bits_address,
  output logic [DATA_W/8-1:0] auto_out_a_bits_mask,
  output logic [DATA_W-1:0]   auto_out_a_bits_data,
  output logic                auto_out_a_bits_corrupt,
  input  logic                auto_out_d_valid,
  output logic                auto_out_d_ready,
  input  logic [2:0]          auto_out_d_bits_opcode,
  input  logic [1:0]          auto_out_d_bits_param,
  input  logic [3:0]          auto_out_d_bits_size,
  input  logic [SRC_W-1:0]    auto_out_d_bits_source,
  input  logic                auto_out_d_bits_sink,
  input  logic                auto_out_d_bits_denied,
  input  logic [DATA_W-1:0]   auto_out_d_bits_data,
  input  logic                auto_out_d_bits_corrupt,
  output logic                auto_in_d_valid,
  input  logic                auto_in_d_ready,
  output logic [2:0]          auto_in_d_bits_opcode,
  output logic [1:0]          auto_in_d_bits_param,
  output logic [3:0]          auto_in_d_bits_size,
  output logic [SRC_W-1:0]    auto_in_d_bits_source,
  output logic                auto_in_d_bits_sink,
  output logic                auto_in_d_bits_denied,
  output logic [DATA_W-1:0]   auto_in_d_bits_data,
  output logic                auto_in_d_bits_corrupt,
  output logic                io_idle,
  output logic                io_underflow
);

  localparam int unsigned LGB = $clog2(DATA_W / 8);

  function automatic logic [7:0] beats_m1(input logic has_data, input logic [3:0] size);
    logic [7:0] r;
    r = '0;
    if (has_data && (size > 4'(LGB))) r = 8'((32'd1 << (size - 4'(LGB))) - 32'd1);
    return r;
  endfunction

  logic [7:0]       a_beat_q, a_beat_d;
  logic [7:0]       d_beat_q, d_beat_d;
  logic [CNT_W-1:0] cnt_q [NUM_GROUPS];
  logic [CNT_W-1:0] cnt_d [NUM_GROUPS];
  logic [ID_W-1:0]  dom_q [NUM_GROUPS];
  logic [ID_W-1:0]  dom_d [NUM_GROUPS];
  logic             uflow_q, uflow_d;

  logic             a_first, a_fire, d_first, d_last, d_fire, stall, a_in_range;
  logic [SRC_W-1:0] a_grp, d_grp;
  logic [ID_W-1:0]  a_dom, a_dom_sel;
  logic [CNT_W-1:0] a_cnt_sel;
  logic [7:0]       a_beats1, d_beats1;

  // Payload and D channel are pure wires.
  assign auto_out_a_bits_opcode  = auto_in_a_bits_opcode;
  assign auto_out_a_bits_param   = auto_in_a_bits_param;
  assign auto_out_a_bits_size    = auto_in_a_bits_size;
  assign auto_out_a_bits_source  = auto_in_a_bits_source;
  assign auto_out_a_bits_address = auto_in_a_bits_address;
  assign auto_out_a_bits_mask    = auto_in_a_bits_mask;
  assign auto_out_a_bits_data    = auto_in_a_bits_data;
  assign auto_out_a_bits_corrupt = auto_in_a_bits_corrupt;
  assign auto_in_d_valid         = auto_out_d_valid;
  assign auto_out_d_ready        = auto_in_d_ready;
  assign auto_in_d_bits_opcode   = auto_out_d_bits_opcode;
  assign auto_in_d_bits_param    = auto_out_d_bits_param;
  assign auto_in_d_bits_size     = auto_out_d_bits_size;
  assign auto_in_d_bits_source   = auto_out_d_bits_source;
  assign auto_in_d_bits_sink     = auto_out_d_bits_sink;
  assign auto_in_d_bits_denied   = auto_out_d_bits_denied;
  assign auto_in_d_bits_data     = auto_out_d_bits_data;
  assign auto_in_d_bits_corrupt  = auto_out_d_bits_corrupt;

  assign a_beats1   = beats_m1(~auto_in_a_bits_opcode[2], auto_in_a_bits_size);
  assign d_beats1   = beats_m1(auto_out_d_bits_opcode == 3'd1 || auto_out_d_bits_opcode == 3'd5,
                               auto_out_d_bits_size);
  assign a_first    = (a_beat_q == '0);
  assign d_first    = (d_beat_q == '0);
  assign d_last     = d_first ? (d_beats1 == '0) : (d_beat_q == 8'd1);
  assign a_grp      = auto_in_a_bits_source >> GROUP_SHIFT;
  assign d_grp      = auto_out_d_bits_source >> GROUP_SHIFT;
  assign a_dom      = auto_in_a_bits_address[ID_LO +: ID_W];
  assign a_in_range = (32'(a_grp) < NUM_GROUPS);

  always_comb begin
    a_cnt_sel = '0;
    a_dom_sel = '0;
    for (int unsigned i = 0; i < NUM_GROUPS; i++) begin
      if (32'(a_grp) == i) begin
        a_cnt_sel = cnt_q[i];
        a_dom_sel = dom_q[i];
      end
    end
  end

  // Stall depends only on registered state and A inputs, never on out_a_ready.
  assign stall = a_in_range && a_first &&
                 (((a_cnt_sel != '0) && (a_dom_sel != a_dom)) || (a_cnt_sel == '1));

  assign auto_out_a_valid = auto_in_a_valid & ~stall;
  assign auto_in_a_ready  = auto_out_a_ready & ~stall;
  assign a_fire           = auto_in_a_valid & auto_in_a_ready;
  assign d_fire           = auto_out_d_valid & auto_in_d_ready;

  always_comb begin
    a_beat_d = a_beat_q;
    d_beat_d = d_beat_q;
    if (a_fire) a_beat_d = a_first ? a_beats1 : a_beat_q - 8'd1;
    if (d_fire) d_beat_d = d_first ? d_beats1 : d_beat_q - 8'd1;
  end

  always_comb begin
    logic inc, dec;
    cnt_d   = cnt_q;
    dom_d   = dom_q;
    uflow_d = uflow_q;
    for (int unsigned i = 0; i < NUM_GROUPS; i++) begin
      inc = a_fire && a_first && (32'(a_grp) == i);
      dec = d_fire && d_last && (32'(d_grp) == i);
      if (inc) dom_d[i] = a_dom;
      if (inc && !dec && (cnt_q[i] != '1)) cnt_d[i] = cnt_q[i] + CNT_W'(1);
      if (dec && !inc) begin
        if (cnt_q[i] == '0) uflow_d = 1'b1;
        else                cnt_d[i] = cnt_q[i] - CNT_W'(1);
      end
    end
  end

  always_comb begin
    io_idle = 1'b1;
    for (int unsigned i = 0; i < NUM_GROUPS; i++) begin
      if (cnt_q[i] != '0) io_idle = 1'b0;
    end
  end

  assign io_underflow = uflow_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      a_beat_q <= '0;
      d_beat_q <= '0;
      uflow_q  <= 1'b0;
      for (int unsigned i = 0; i < NUM_GROUPS; i++) begin
        cnt_q[i] <= '0;
        dom_q[i] <= '0;
      end
    end else begin
      a_beat_q <= a_beat_d;
      d_beat_q <= d_beat_d;
      uflow_q  <= uflow_d;
      cnt_q    <= cnt_d;
      dom_q    <= dom_d;
    end
  end

endmodule

// File: tb/tb_tl_fifo_fixer_ordered.sv
// Scoreboard bench for tl_fifo_fixer_ordered: A beats expected downstream are queued when driven
// and popped when they fire; group tracking is observed through stall, io_idle and io_underflow.
module tb_tl_fifo_fixer_ordered;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_a_valid, in_a_ready, out_a_valid, out_a_ready;
  logic [2:0]  in_a_opcode, in_a_param, out_a_opcode, out_a_param;
  logic [3:0]  in_a_size, out_a_size;
  logic [7:0]  in_a_source, out_a_source, in_a_mask, out_a_mask;
  logic [30:0] in_a_address, out_a_address;
  logic [63:0] in_a_data, out_a_data;
  logic        in_a_corrupt, out_a_corrupt;
  logic        out_d_valid, out_d_ready, in_d_valid, in_d_ready;
  logic [2:0]  od_opcode, id_opcode;
  logic [1:0]  od_param, id_param;
  logic [3:0]  od_size, id_size;
  logic [7:0]  od_source, id_source;
  logic        od_sink, id_sink, od_denied, id_denied, od_corrupt, id_corrupt;
  logic [63:0] od_data, id_data;
  logic        io_idle, io_underflow;

  int unsigned  n_cmp = 0;
  int unsigned  n_bad = 0;
  logic [127:0] exp_q[$];

  always #5 clock = ~clock;

  tl_fifo_fixer_ordered #(.NUM_GROUPS(8)) dut (
    .clock(clock), .reset(reset),
    .auto_in_a_valid(in_a_valid), .auto_in_a_ready(in_a_ready),
    .auto_in_a_bits_opcode(in_a_opcode), .auto_in_a_bits_param(in_a_param),
    .auto_in_a_bits_size(in_a_size), .auto_in_a_bits_source(in_a_source),
    .auto_in_a_bits_address(in_a_address), .auto_in_a_bits_mask(in_a_mask),
    .auto_in_a_bits_data(in_a_data), .auto_in_a_bits_corrupt(in_a_corrupt),
    .auto_out_a_valid(out_a_valid), .auto_out_a_ready(out_a_ready),
    .auto_out_a_bits_opcode(out_a_opcode), .auto_out_a_bits_param(out_a_param),
    .auto_out_a_bits_size(out_a_size), .auto_out_a_bits_source(out_a_source),
    .auto_out_a_bits_address(out_a_address), .auto_out_a_bits_mask(out_a_mask),
    .auto_out_a_bits_data(out_a_data), .auto_out_a_bits_corrupt(out_a_corrupt),
    .auto_out_d_valid(out_d_valid), .auto_out_d_ready(out_d_ready),
    .auto_out_d_bits_opcode(od_opcode), .auto_out_d_bits_param(od_param),
    .auto_out_d_bits_size(od_size), .auto_out_d_bits_source(od_source),
    .auto_out_d_bits_sink(od_sink), .auto_out_d_bits_denied(od_denied),
    .auto_out_d_bits_data(od_data), .auto_out_d_bits_corrupt(od_corrupt),
    .auto_in_d_valid(in_d_valid), .auto_in_d_ready(in_d_ready),
    .auto_in_d_bits_opcode(id_opcode), .auto_in_d_bits_param(id_param),
    .auto_in_d_bits_size(id_size), .auto_in_d_bits_source(id_source),
    .auto_in_d_bits_sink(id_sink), .auto_in_d_bits_denied(id_denied),
    .auto_in_d_bits_data(id_data), .auto_in_d_bits_corrupt(id_corrupt),
    .io_idle(io_idle), .io_underflow(io_underflow)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Downstream A fires are matched in order against the queued expectations.
  always @(negedge clock) begin
    if (!reset && out_a_valid && out_a_ready) begin
      if (exp_q.size() == 0) check("sb_unexpected_fire", 128'(exp_q.size()), 128'd1);
      else check("a_payload", {6'b0, out_a_opcode, out_a_param, out_a_size, out_a_source,
                               out_a_address, out_a_mask, out_a_data, out_a_corrupt},
                 exp_q.pop_front());
    end
  end

  task automatic drive_a(input logic [2:0] op, input logic [3:0] sz, input logic [7:0] src,
                         input logic [30:0] addr, input bit push);
    in_a_valid   = 1'b1;
    in_a_opcode  = op;
    in_a_param   = 3'($urandom_range(0, 7));
    in_a_size    = sz;
    in_a_source  = src;
    in_a_address = addr;
    in_a_mask    = 8'($urandom);
    in_a_data    = {$urandom, $urandom};
    in_a_corrupt = 1'($urandom_range(0, 1));
    if (push) exp_q.push_back({6'b0, in_a_opcode, in_a_param, in_a_size, in_a_source,
                               in_a_address, in_a_mask, in_a_data, in_a_corrupt});
  endtask

  task automatic send_a(input logic [2:0] op, input logic [3:0] sz, input logic [7:0] src,
                        input logic [30:0] addr);
    int unsigned n;
    drive_a(op, sz, src, addr, 1'b1);
    #1;
    n = 0;
    while (!in_a_ready && n < 20) begin
      @(posedge clock); #1;
      n++;
    end
    check("a_accept", 128'(in_a_ready), 128'd1);
    @(posedge clock); #1;
    in_a_valid = 1'b0;
  endtask

  task automatic send_burst(input logic [7:0] src, input logic [30:0] addr, input int unsigned nb);
    for (int unsigned b = 0; b < nb; b++) begin
      drive_a(3'd0, 4'd6, src, addr, 1'b1);
      #1;
      check("burst_no_gap", 128'(in_a_ready), 128'd1);
      @(posedge clock); #1;
    end
    in_a_valid = 1'b0;
  endtask

  task automatic set_d(input logic [2:0] op, input logic [3:0] sz, input logic [7:0] src);
    out_d_valid = 1'b1;
    od_opcode   = op;
    od_param    = 2'($urandom_range(0, 3));
    od_size     = sz;
    od_source   = src;
    od_sink     = 1'($urandom_range(0, 1));
    od_denied   = 1'($urandom_range(0, 1));
    od_data     = {$urandom, $urandom};
    od_corrupt  = 1'($urandom_range(0, 1));
  endtask

  task automatic send_d(input logic [2:0] op, input logic [3:0] sz, input logic [7:0] src,
                        input int unsigned nb);
    for (int unsigned b = 0; b < nb; b++) begin
      set_d(op, sz, src);
      #1;
      check("d_pass", {in_d_valid, out_d_ready, id_opcode, id_param, id_size, id_source,
                       id_sink, id_denied, id_data, id_corrupt},
            {1'b1, in_d_ready, od_opcode, od_param, od_size, od_source,
             od_sink, od_denied, od_data, od_corrupt});
      @(posedge clock); #1;
    end
    out_d_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    out_a_ready = 1'b1;
    in_d_ready = 1'b1;
    out_d_valid = 1'b0;
    set_d(3'd0, 4'd0, 8'd0);
    out_d_valid = 1'b0;
    drive_a(3'd4, 4'd3, 8'h10, 31'h1000_0000, 1'b0);
    #1;
    check("rst_out_a_valid", 128'(out_a_valid), 128'd1);
    check("rst_idle", 128'(io_idle), 128'd1);
    check("rst_underflow", 128'(io_underflow), 128'd0);
    in_a_valid = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;

    // Basic Get / AccessAckData; D held back by client ready first
    send_a(3'd4, 4'd3, 8'h10, 31'h1000_0000);
    check("get_busy", 128'(io_idle), 128'd0);
    set_d(3'd1, 4'd3, 8'h10);
    in_d_ready = 1'b0;
    #1;
    check("d_ready_follow", 128'(out_d_ready), 128'd0);
    @(posedge clock); #1;
    check("d_blocked_no_dec", 128'(io_idle), 128'd0);
    in_d_ready = 1'b1;
    send_d(3'd1, 4'd3, 8'h10, 1);
    check("ack_idle", 128'(io_idle), 128'd1);

    // Downstream backpressure must not gate valid
    drive_a(3'd4, 4'd3, 8'h60, 31'h0, 1'b1);
    out_a_ready = 1'b0;
    #1;
    check("bp_in_ready", 128'(in_a_ready), 128'd0);
    check("bp_out_valid", 128'(out_a_valid), 128'd1);
    @(posedge clock); #1;
    out_a_ready = 1'b1;
    #1;
    check("bp_release", 128'(in_a_ready), 128'd1);
    @(posedge clock); #1;
    in_a_valid = 1'b0;
    send_d(3'd1, 4'd3, 8'h60, 1);

    // Domain conflict stalls until the group drains; release is one cycle later
    send_a(3'd4, 4'd3, 8'h10, 31'h1000_0000);
    drive_a(3'd4, 4'd3, 8'h13, 31'h2000_0000, 1'b1);
    #1;
    check("conf_in_ready", 128'(in_a_ready), 128'd0);
    check("conf_out_valid", 128'(out_a_valid), 128'd0);
    @(posedge clock); #1;
    check("conf_hold", 128'(in_a_ready), 128'd0);
    set_d(3'd1, 4'd3, 8'h10);
    #1;
    check("conf_same_cycle", 128'(in_a_ready), 128'd0);
    @(posedge clock); #1;
    out_d_valid = 1'b0;
    #1;
    check("conf_release_rdy", 128'(in_a_ready), 128'd1);
    check("conf_release_vld", 128'(out_a_valid), 128'd1);
    @(posedge clock); #1;
    in_a_valid = 1'b0;
    send_a(3'd4, 4'd3, 8'h11, 31'h2000_0000);
    send_d(3'd1, 4'd3, 8'h10, 2);
    check("conf_drained", 128'(io_idle), 128'd1);

    // 8-beat burst counted once, 8-beat response decrements on its last beat
    send_burst(8'h20, 31'h0, 8);
    check("burst_busy", 128'(io_idle), 128'd0);
    send_d(3'd1, 4'd6, 8'h20, 7);
    check("d_not_last", 128'(io_idle), 128'd0);
    send_d(3'd1, 4'd6, 8'h20, 1);
    check("d_last_idle", 128'(io_idle), 128'd1);

    // Counter saturation stalls the 16th; other groups unaffected
    for (int unsigned k = 0; k < 15; k++) send_a(3'd4, 4'd3, 8'h30, 31'h0);
    drive_a(3'd4, 4'd3, 8'h30, 31'h0, 1'b0);
    #1;
    check("sat_stall", 128'(in_a_ready), 128'd0);
    @(posedge clock); #1;
    check("sat_stall_hold", 128'(out_a_valid), 128'd0);
    in_a_valid = 1'b0;
    send_a(3'd4, 4'd3, 8'h40, 31'h3000_0000);
    send_d(3'd1, 4'd3, 8'h30, 14);
    check("sat_partial", 128'(io_idle), 128'd0);
    send_d(3'd1, 4'd3, 8'h30, 1);
    send_d(3'd1, 4'd3, 8'h40, 1);
    check("sat_drained", 128'(io_idle), 128'd1);

    // Untracked group
    send_a(3'd4, 4'd3, 8'hF0, 31'h1000_0000);
    check("ungrp_idle", 128'(io_idle), 128'd1);
    send_a(3'd4, 4'd3, 8'hF5, 31'h2000_0000);
    send_d(3'd1, 4'd3, 8'hF0, 1);
    check("ungrp_no_uflow", 128'(io_underflow), 128'd0);

    // Same-cycle increment and decrement on one group
    send_a(3'd4, 4'd3, 8'h10, 31'h1000_0000);
    drive_a(3'd4, 4'd3, 8'h12, 31'h1000_0000, 1'b1);
    set_d(3'd1, 4'd3, 8'h10);
    #1;
    check("same_cyc_rdy", 128'(in_a_ready), 128'd1);
    @(posedge clock); #1;
    in_a_valid = 1'b0;
    out_d_valid = 1'b0;
    check("same_cyc_kept", 128'(io_idle), 128'd0);
    send_d(3'd1, 4'd3, 8'h10, 1);
    check("same_cyc_one", 128'(io_idle), 128'd1);
    check("same_cyc_no_uflow", 128'(io_underflow), 128'd0);

    // Underflow is sticky
    send_d(3'd0, 4'd3, 8'h50, 1);
    check("uflow_set", 128'(io_underflow), 128'd1);
    send_a(3'd4, 4'd3, 8'h50, 31'h0);
    send_d(3'd0, 4'd3, 8'h50, 1);
    check("uflow_sticky", 128'(io_underflow), 128'd1);
    check("uflow_cnt_ok", 128'(io_idle), 128'd1);

    // Reset in the middle of a burst
    send_burst(8'h20, 31'h0, 3);
    check("mid_burst_busy", 128'(io_idle), 128'd0);
    reset = 1'b1;
    #1;
    check("async_rst_uflow", 128'(io_underflow), 128'd0);
    check("async_rst_idle", 128'(io_idle), 128'd1);
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;
    send_a(3'd4, 4'd3, 8'h20, 31'h1000_0000);
    check("post_rst_first", 128'(io_idle), 128'd0);
    send_d(3'd1, 4'd3, 8'h20, 1);
    check("post_rst_drain", 128'(io_idle), 128'd1);

    @(posedge clock); #1;
    check("sb_drained", 128'(exp_q.size()), 128'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
